// File: rtl/cam_allocator_rr_pkg.sv
// cam_allocator_rr_pkg: shared widths, response layout and index helper for the CU free-segment CAM.
// The localparams describe the default configuration (8 CUs, 10-bit resource addresses).
// cam_resp_t is the packed response {hit, mask, cu, start} at those default widths.
package cam_allocator_rr_pkg;

  localparam int CAM_NUM_CU       = 8;
  localparam int CAM_CU_ID_WIDTH  = $clog2(CAM_NUM_CU);
  localparam int CAM_RES_ID_WIDTH = 10;
  localparam int CAM_SIZE_WIDTH   = CAM_RES_ID_WIDTH + 1;

  typedef struct packed {
    logic                        hit;
    logic [CAM_NUM_CU-1:0]       mask;
    logic [CAM_CU_ID_WIDTH-1:0]  cu;
    logic [CAM_RES_ID_WIDTH-1:0] start;
  } cam_resp_t;

  // Index one past idx, wrapping to 0 after the last CU.
  function automatic int cam_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cam_allocator_rr_select.sv
// cam_rr_select: picks the first set bit of a match mask at or after a start pointer, wrapping.
// Purely combinational, zero latency; no handshake.
// A zero mask reports hit=0 and index 0; a zero pointer degenerates to a lowest-index priority encoder.
module cam_rr_select
  import cam_allocator_rr_pkg::*;
#(
  parameter int NUM_CU      = CAM_NUM_CU,
  parameter int CU_ID_WIDTH = $clog2(NUM_CU)
) (
  input  logic [NUM_CU-1:0]      mask,
  input  logic [CU_ID_WIDTH-1:0] ptr,
  output logic                   hit,
  output logic [CU_ID_WIDTH-1:0] idx
);

  // Walk the rotated order from the far end so the nearest match to the pointer wins last.
  always_comb begin
    int j;
    j   = 0;
    hit = |mask;
    idx = '0;
    for (int k = NUM_CU - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_CU) begin
        j = j - NUM_CU;
      end
      if (mask[j]) begin
        idx = CU_ID_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/cam_allocator_rr.sv
// cam_allocator_rr: per-CU free-segment CAM, 2-stage search pipeline (S1 request, S2 response).
// Latency: request accepted in cycle N responds in cycle N+2; sustains 1 request per cycle.
// Backpressure: a stalled response holds S2, then S1, then req_ready_o drops. Build macro CAM_ALLOC_RR_EN selects round-robin.
module cam_allocator_rr
  import cam_allocator_rr_pkg::*;
#(
  parameter int NUM_CU       = CAM_NUM_CU,
  parameter int CU_ID_WIDTH  = $clog2(NUM_CU),
  parameter int RES_ID_WIDTH = CAM_RES_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_wr_en_i,
  input  logic [CU_ID_WIDTH-1:0]  alloc_wr_cu_i,
  input  logic [RES_ID_WIDTH:0]   alloc_wr_size_i,
  input  logic [RES_ID_WIDTH-1:0] alloc_wr_start_i,
  input  logic                    dealloc_wr_en_i,
  input  logic [CU_ID_WIDTH-1:0]  dealloc_wr_cu_i,
  input  logic [RES_ID_WIDTH:0]   dealloc_wr_size_i,
  input  logic [RES_ID_WIDTH-1:0] dealloc_wr_start_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [RES_ID_WIDTH:0]   req_size_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    resp_hit_o,
  output logic [NUM_CU-1:0]       resp_mask_o,
  output logic [CU_ID_WIDTH-1:0]  resp_cu_o,
  output logic [RES_ID_WIDTH-1:0] resp_start_o
);

  localparam int SIZE_WIDTH = RES_ID_WIDTH + 1;

  typedef struct packed {
    logic                    hit;
    logic [NUM_CU-1:0]       mask;
    logic [CU_ID_WIDTH-1:0]  cu;
    logic [RES_ID_WIDTH-1:0] start;
  } resp_t;

  // Entry table
  logic [SIZE_WIDTH-1:0]   ent_size  [NUM_CU];
  logic [RES_ID_WIDTH-1:0] ent_start [NUM_CU];
  logic [NUM_CU-1:0]       ent_valid;

  // Pipeline state
  logic                  s1_valid;
  logic [SIZE_WIDTH-1:0] s1_size;
  logic                  s1_adv;
  logic                  s2_valid;
  resp_t                 s2_resp;
  resp_t                 resp_nxt;

  // Search datapath
  logic [NUM_CU-1:0]      match;
  logic [CU_ID_WIDTH-1:0] sel_ptr;
  logic                   sel_hit;
  logic [CU_ID_WIDTH-1:0] sel_idx;

  assign s1_adv      = !s2_valid || resp_ready_i;
  assign req_ready_o = !s1_valid || s1_adv;

  // Table update; the dealloc port overrides alloc when both hit the same CU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CU; i++) begin
        ent_size[i]  <= '0;
        ent_start[i] <= '0;
      end
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_CU; i++) begin
        if (dealloc_wr_en_i && (dealloc_wr_cu_i == CU_ID_WIDTH'(i))) begin
          ent_size[i]  <= dealloc_wr_size_i;
          ent_start[i] <= dealloc_wr_start_i;
          ent_valid[i] <= 1'b1;
        end else if (alloc_wr_en_i && (alloc_wr_cu_i == CU_ID_WIDTH'(i))) begin
          ent_size[i]  <= alloc_wr_size_i;
          ent_start[i] <= alloc_wr_start_i;
          ent_valid[i] <= 1'b1;
        end
      end
    end
  end

  // S1 holds the request size until S2 can take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_size  <= '0;
    end else if (req_valid_i && req_ready_o) begin
      s1_valid <= 1'b1;
      s1_size  <= req_size_i;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Never-written entries advertise the whole resource space, so they match anything.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CU; i++) begin
      match[i] = !ent_valid[i] || (ent_size[i] >= s1_size);
    end
  end

`ifdef CAM_ALLOC_RR_EN
  logic [CU_ID_WIDTH-1:0] rr_ptr;
  logic                   resp_hit_fire;

  assign resp_hit_fire = s2_valid && resp_ready_i && s2_resp.hit;

  // A hit leaving S2 moves the pointer for the request entering S2 on the same edge.
  always_comb begin
    sel_ptr = rr_ptr;
    if (resp_hit_fire) begin
      sel_ptr = (s2_resp.cu == CU_ID_WIDTH'(NUM_CU - 1)) ? '0 : s2_resp.cu + CU_ID_WIDTH'(1);
    end
  end

  // Round-robin pointer register tracks the forwarded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= sel_ptr;
    end
  end
`else
  assign sel_ptr = '0;
`endif

  cam_rr_select #(
    .NUM_CU      (NUM_CU),
    .CU_ID_WIDTH (CU_ID_WIDTH)
  ) u_select (
    .mask (match),
    .ptr  (sel_ptr),
    .hit  (sel_hit),
    .idx  (sel_idx)
  );

  // Build the response; bubbles and misses produce an all-zero result.
  always_comb begin
    resp_nxt = '0;
    if (s1_valid && sel_hit) begin
      resp_nxt.hit   = 1'b1;
      resp_nxt.mask  = match;
      resp_nxt.cu    = sel_idx;
      resp_nxt.start = ent_start[sel_idx];
    end
  end

  // S2 response register freezes while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_resp  <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      s2_resp  <= resp_nxt;
    end
  end

  assign resp_valid_o = s2_valid;
  assign resp_hit_o   = s2_resp.hit;
  assign resp_mask_o  = s2_resp.mask;
  assign resp_cu_o    = s2_resp.cu;
  assign resp_start_o = s2_resp.start;

endmodule

// File: tb/tb_cam_allocator_rr.sv
// tb_cam_allocator_rr: directed and randomized checks of cam_allocator_rr against a table/queue model.
// Works with or without CAM_ALLOC_RR_EN; the model follows the same macro.
// Responses are compared at each handshake, and held outputs are compared while stalled.
module tb_cam_allocator_rr;
  import cam_allocator_rr_pkg::*;

  localparam int N  = CAM_NUM_CU;
  localparam int CW = CAM_CU_ID_WIDTH;
  localparam int RW = CAM_RES_ID_WIDTH;
  localparam int SW = CAM_SIZE_WIDTH;
`ifdef CAM_ALLOC_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          alloc_wr_en_i = 1'b0;
  logic [CW-1:0] alloc_wr_cu_i = '0;
  logic [SW-1:0] alloc_wr_size_i = '0;
  logic [RW-1:0] alloc_wr_start_i = '0;
  logic          dealloc_wr_en_i = 1'b0;
  logic [CW-1:0] dealloc_wr_cu_i = '0;
  logic [SW-1:0] dealloc_wr_size_i = '0;
  logic [RW-1:0] dealloc_wr_start_i = '0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [SW-1:0] req_size_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic          resp_hit_o;
  logic [N-1:0]  resp_mask_o;
  logic [CW-1:0] resp_cu_o;
  logic [RW-1:0] resp_start_o;

  cam_allocator_rr dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alloc_wr_en_i      (alloc_wr_en_i),
    .alloc_wr_cu_i      (alloc_wr_cu_i),
    .alloc_wr_size_i    (alloc_wr_size_i),
    .alloc_wr_start_i   (alloc_wr_start_i),
    .dealloc_wr_en_i    (dealloc_wr_en_i),
    .dealloc_wr_cu_i    (dealloc_wr_cu_i),
    .dealloc_wr_size_i  (dealloc_wr_size_i),
    .dealloc_wr_start_i (dealloc_wr_start_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_size_i         (req_size_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_hit_o         (resp_hit_o),
    .resp_mask_o        (resp_mask_o),
    .resp_cu_o          (resp_cu_o),
    .resp_start_o       (resp_start_o)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: table contents, selection pointer, outstanding request sizes.
  bit        m_valid [N];
  int        m_size  [N];
  int        m_start [N];
  int        m_ptr;
  int        pend[$];
  int        got_cu[$];
  int        hs_count;
  bit        hold_pend;
  cam_resp_t held;
  cam_resp_t last_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cam_resp_t obs_resp();
    cam_resp_t r;
    r = {resp_hit_o, resp_mask_o, resp_cu_o, resp_start_o};
    return r;
  endfunction

  function automatic cam_resp_t mk_resp(input bit h, input int mask, input int cu, input int st);
    cam_resp_t r;
    r.hit   = h;
    r.mask  = N'(mask);
    r.cu    = CW'(cu);
    r.start = RW'(st);
    return r;
  endfunction

  // Expected answer for a request of size sz, from the table and pointer rules.
  function automatic cam_resp_t model_resp(input int sz);
    cam_resp_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i] || m_size[i] >= sz) r.mask[i] = 1'b1;
    end
    r.hit = |r.mask;
    if (r.hit) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r.mask[c]) begin
          r.cu    = CW'(c);
          r.start = RW'(m_start[c]);
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic void model_consume(input cam_resp_t r);
    if (RR && r.hit) m_ptr = (int'(r.cu) + 1) % N;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    alloc_wr_en_i = 1'b0;
    dealloc_wr_en_i = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid_o), 32'(0));
    chk("rst_resp_fields", 32'(obs_resp()), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_size[i] = 0;
      m_start[i] = 0;
    end
    m_ptr = 0;
    pend.delete();
    hold_pend = 1'b0;
  endtask

  task automatic wr(input bit port, input int cu, input int sz, input int st);
    if (port) begin
      dealloc_wr_en_i = 1'b1; dealloc_wr_cu_i = CW'(cu);
      dealloc_wr_size_i = SW'(sz); dealloc_wr_start_i = RW'(st);
    end else begin
      alloc_wr_en_i = 1'b1; alloc_wr_cu_i = CW'(cu);
      alloc_wr_size_i = SW'(sz); alloc_wr_start_i = RW'(st);
    end
    @(posedge clk); #1;
    alloc_wr_en_i = 1'b0;
    dealloc_wr_en_i = 1'b0;
    m_valid[cu] = 1'b1; m_size[cu] = sz; m_start[cu] = st;
  endtask

  // Same-cycle writes from both ports to one CU; the dealloc value must stick.
  task automatic wr_both(input int cu, input int s0, input int t0, input int s1, input int t1);
    alloc_wr_en_i = 1'b1; alloc_wr_cu_i = CW'(cu);
    alloc_wr_size_i = SW'(s0); alloc_wr_start_i = RW'(t0);
    dealloc_wr_en_i = 1'b1; dealloc_wr_cu_i = CW'(cu);
    dealloc_wr_size_i = SW'(s1); dealloc_wr_start_i = RW'(t1);
    @(posedge clk); #1;
    alloc_wr_en_i = 1'b0;
    dealloc_wr_en_i = 1'b0;
    m_valid[cu] = 1'b1; m_size[cu] = s1; m_start[cu] = t1;
  endtask

  // One clock of traffic: drive, sample before the edge, score handshakes, advance.
  task automatic cycle(input bit v, input int sz, input bit rdy, output bit acc);
    cam_resp_t o, e;
    req_valid_i = v;
    req_size_i = SW'(sz);
    resp_ready_i = rdy;
    #2;
    o = obs_resp();
    if (hold_pend) chk("hold_stable", 32'({resp_valid_o, o}), 32'({1'b1, held}));
    acc = v && req_ready_o;
    if (resp_valid_o && rdy) begin
      chk("resp_expected", 32'(pend.size() != 0), 32'(1));
      if (pend.size() != 0) begin
        e = model_resp(pend.pop_front());
        chk("resp_match", 32'(o), 32'(e));
        model_consume(e);
      end
      last_resp = o;
      got_cu.push_back(int'(o.cu));
      hs_count++;
    end
    hold_pend = resp_valid_o && !rdy;
    held = o;
    if (acc) pend.push_back(sz);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit a;
    for (int k = 0; k < 20 && (pend.size() != 0 || resp_valid_o); k++) cycle(1'b0, 0, 1'b1, a);
    req_valid_i = 1'b0;
    chk("drain_empty", 32'(pend.size()), 32'(0));
    chk("drain_idle", 32'(resp_valid_o), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int idx;
    int bp_sz[3];

    // Reset state and first-request latency on an empty table.
    reset_dut();
    cycle(1'b1, 5, 1'b1, a);
    chk("t1_accept", 32'(a), 32'(1));
    chk("t1_lat_n1", 32'(resp_valid_o), 32'(0));
    cycle(1'b0, 0, 1'b1, a);
    chk("t1_lat_n2", 32'(resp_valid_o), 32'(1));
    chk("t1_resp", 32'(obs_resp()), 32'(mk_resp(1'b1, 'hFF, 0, 0)));
    cycle(1'b0, 0, 1'b1, a);
    drain();

    // Only the large entry satisfies the request.
    for (int i = 0; i < N; i++) wr(i[0], i, 3, i + 1);
    wr(1'b0, 5, 40, 100);
    cycle(1'b1, 20, 1'b1, a);
    drain();
    chk("t2_resp", 32'(last_resp), 32'(mk_resp(1'b1, 'h20, 5, 100)));

    // Dealloc port wins a same-cycle collision: CU2 ends at size 50 start 55.
    wr_both(2, 10, 11, 50, 55);
    cycle(1'b1, 30, 1'b1, a);
    drain();
    chk("t3_resp", 32'(last_resp), 32'(mk_resp(1'b1, 'h24, 2, 55)));

    // Miss returns all zeros; size 0 matches everything.
    for (int i = 0; i < N; i++) wr(1'b0, i, 1, 3 * i);
    cycle(1'b1, 2, 1'b1, a);
    drain();
    chk("t4_miss", 32'(last_resp), 32'(0));
    cycle(1'b1, 0, 1'b1, a);
    drain();
    chk("t4_zero_mask", 32'(last_resp.mask), 32'('hFF));

    // A write landing on the S2 capture edge is not seen.
    req_valid_i = 1'b1; req_size_i = SW'(20); resp_ready_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    alloc_wr_en_i = 1'b1; alloc_wr_cu_i = CW'(3);
    alloc_wr_size_i = SW'(50); alloc_wr_start_i = RW'(7);
    @(posedge clk); #1;
    alloc_wr_en_i = 1'b0;
    m_valid[3] = 1'b1; m_size[3] = 50; m_start[3] = 7;
    chk("vis_same_valid", 32'(resp_valid_o), 32'(1));
    chk("vis_same_resp", 32'(obs_resp()), 32'(0));
    @(posedge clk); #1;

    // A write one cycle before capture is seen.
    req_valid_i = 1'b1; req_size_i = SW'(55);
    dealloc_wr_en_i = 1'b1; dealloc_wr_cu_i = CW'(4);
    dealloc_wr_size_i = SW'(60); dealloc_wr_start_i = RW'(9);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    dealloc_wr_en_i = 1'b0;
    m_valid[4] = 1'b1; m_size[4] = 60; m_start[4] = 9;
    @(posedge clk); #1;
    chk("vis_early_valid", 32'(resp_valid_o), 32'(1));
    chk("vis_early_resp", 32'(obs_resp()), 32'(mk_resp(1'b1, 'h10, 4, 9)));
    model_consume(mk_resp(1'b1, 'h10, 4, 9));
    @(posedge clk); #1;
    drain();

    // Consumer stalls 4 cycles with 3 requests offered: 2 accepted, outputs held, none lost.
    bp_sz[0] = 4; bp_sz[1] = 5; bp_sz[2] = 6;
    idx = 0;
    hs_count = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, bp_sz[idx], 1'b0, a);
      if (a) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'(2));
    chk("bp_ready_low", 32'(req_ready_o), 32'(0));
    for (int c = 0; c < 10 && idx < 3; c++) begin
      cycle(1'b1, bp_sz[idx], 1'b1, a);
      if (a) idx++;
    end
    chk("bp_third_accepted", 32'(idx), 32'(3));
    drain();
    chk("bp_responses", 32'(hs_count), 32'(3));

    // Reset with the pipeline full: everything in flight and every entry is dropped.
    cycle(1'b1, 9, 1'b0, a);
    cycle(1'b1, 9, 1'b0, a);
    cycle(1'b1, 9, 1'b0, a);
    reset_dut();
    cycle(1'b1, 1024, 1'b1, a);
    drain();
    chk("rst_entries_invalid", 32'(last_resp), 32'(mk_resp(1'b1, 'hFF, 0, 0)));

    // Back-to-back selection from a fresh pointer with every CU matching.
    reset_dut();
    got_cu.delete();
    for (int k = 0; k < 3; k++) cycle(1'b1, 7, 1'b1, a);
    drain();
    chk("rr_count", 32'(got_cu.size()), 32'(3));
    for (int k = 0; k < 3 && k < got_cu.size(); k++) chk("rr_cu", 32'(got_cu[k]), 32'(RR ? k : 0));

    // Randomized table contents and traffic.
    reset_dut();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0)
          wr($urandom_range(0, 1) == 1, i, int'($urandom_range(0, 1024)), int'($urandom_range(0, 1023)));
      end
      wr_both(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 1024)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1024)), int'($urandom_range(0, 1023)));
      for (int c = 0; c < 60; c++)
        cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 1024)), $urandom_range(0, 3) != 0, a);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
